// File: rtl/mips_fetch_pkg.sv
// Shared definitions for the MIPS instruction fetch stage: FSM state
// encodings, word size, default reset vector and the NOP instruction.
package mips_fetch_pkg;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t FETCH = 2'd1;
    localparam fetch_state_t HOLD  = 2'd2;
    localparam fetch_state_t ERR   = 2'd3;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0000;

    // A fetch address is legal only if it points at a whole word.
    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/mips_fetch_timer.sv
// Watchdog counter for an outstanding instruction memory request.
// terminal goes high once the count reaches TIMEOUT-1.
module mips_fetch_timer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       enable,
    output logic       terminal
);

    localparam logic [7:0] TERMINAL_COUNT = 8'(TIMEOUT - 1);

    logic [7:0] count;

    // Clear beats load, load beats a normal increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    assign terminal = (count == TERMINAL_COUNT);

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the PC, requests words from instruction
// memory over req/ack and hands each instruction with its PC to decode over
// valid/ready. Redirects squash in-flight fetches; a memory timeout or a
// misaligned redirect traps into a sticky error state left only by reset.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    fetch_state_t state;
    logic [31:0]  pc;
    logic         squash;
    logic         timer_enable;
    logic         timer_done;

    // The watchdog only runs while a request is outstanding and unanswered.
    assign timer_enable = (state == FETCH) && imem_req && !imem_ack;

    mips_fetch_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (!timer_enable),
        .load      (1'b0),
        .load_value(8'd0),
        .enable    (timer_enable),
        .terminal  (timer_done)
    );

    // Fetch FSM: redirect first, then ack handling, then the timeout trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            squash      <= 1'b0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= '0;
            fetch_err   <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (redirect_valid) begin
                        if (is_aligned(redirect_pc)) begin
                            pc          <= redirect_pc;
                            instr_valid <= 1'b0;
                            imem_req    <= 1'b1;
                            imem_addr   <= redirect_pc;
                            state       <= FETCH;
                        end else begin
                            state       <= ERR;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b0;
                            fetch_err   <= 1'b1;
                            squash      <= 1'b0;
                        end
                    end else if (state == IDLE || instr_ready) begin
                        instr_valid <= 1'b0;
                        imem_req    <= 1'b1;
                        imem_addr   <= {pc[31:2], 2'b00};
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    if (redirect_valid && !is_aligned(redirect_pc)) begin
                        state       <= ERR;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        fetch_err   <= 1'b1;
                        squash      <= 1'b0;
                    end else if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (!imem_req) begin
                            imem_req  <= 1'b1;
                            imem_addr <= redirect_pc;
                        end else if (imem_ack) begin
                            imem_req <= 1'b0;
                            squash   <= 1'b0;
                        end else if (timer_done) begin
                            state       <= ERR;
                            imem_req    <= 1'b0;
                            instr_valid <= 1'b0;
                            fetch_err   <= 1'b1;
                            squash      <= 1'b0;
                        end else begin
                            squash <= 1'b1;
                        end
                    end else if (!imem_req) begin
                        imem_req  <= 1'b1;
                        imem_addr <= {pc[31:2], 2'b00};
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        squash   <= 1'b0;
                        if (!squash) begin
                            instr       <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + 32'(WORD_BYTES);
                            state       <= HOLD;
                        end
                    end else if (timer_done) begin
                        state       <= ERR;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        fetch_err   <= 1'b1;
                        squash      <= 1'b0;
                    end
                end
                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    fetch_err   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed testbench for mips_fetch_unit: sequential fetches, decode
// back-pressure, redirect with squash, redirect in HOLD, PC wrap, memory
// timeout, misaligned redirect and reset recovery.
module tb_mips_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    mips_fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .fetch_err     (fetch_err)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next falling edge, where outputs are stable.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a memory request to be visible.
    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        assert (imem_req === 1'b1) else begin
            errors++;
            $error("[TB] FAIL %s_req_wait: observed imem_req %b expected 1 within 40 cycles", tag, imem_req);
        end
    endtask

    // Answer one request: check its address, wait, then ack for one cycle.
    task automatic serve(input string tag, input logic [31:0] exp_addr,
                         input logic [31:0] data, input int delay);
        wait_req(tag);
        check({tag, "_addr"}, imem_addr, exp_addr);
        repeat (delay) step();
        imem_ack   = 1'b1;
        imem_rdata = data;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        instr_ready    = 1'b1;

        #2;
        check("rst_req",   {31'b0, imem_req},    32'd0);
        check("rst_addr",  imem_addr,            32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr,                32'h0);
        check("rst_ipc",   instr_pc,             32'h0);
        check("rst_err",   {31'b0, fetch_err},   32'd0);

        step();
        rst_n = 1'b1;

        // Sequential fetches with a one-cycle ack and decode always ready
        serve("f0", 32'h0, 32'h3442_1862, 0);
        check("f0_valid", {31'b0, instr_valid}, 32'd1);
        check("f0_instr", instr, 32'h3442_1862);
        check("f0_ipc",   instr_pc, 32'h0);
        check("f0_req",   {31'b0, imem_req}, 32'd0);
        serve("f1", 32'h4, 32'h8C43_0000, 0);
        check("f1_instr", instr, 32'h8C43_0000);
        check("f1_ipc",   instr_pc, 32'h4);
        serve("f2", 32'h8, 32'h0062_1020, 0);
        check("f2_ipc",   instr_pc, 32'h8);

        // Decode back-pressure holds the instruction and stalls fetch
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", {31'b0, instr_valid}, 32'd1);
            check("bp_instr", instr, 32'h0062_1020);
            check("bp_req",   {31'b0, imem_req}, 32'd0);
        end
        instr_ready = 1'b1;
        serve("f3", 32'hC, 32'h1234_5678, 0);
        check("f3_ipc", instr_pc, 32'hC);

        // Redirect while the request to 0x10 is outstanding; late ack is squashed
        wait_req("rd");
        check("rd_addr", imem_addr, 32'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("rd_req_held",  {31'b0, imem_req}, 32'd1);
        check("rd_addr_held", imem_addr, 32'h10);
        step();
        step();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        check("sq_valid", {31'b0, instr_valid}, 32'd0);
        check("sq_drop",  {31'b0, imem_req}, 32'd0);
        step();
        check("sq_req",  {31'b0, imem_req}, 32'd1);
        check("sq_addr", imem_addr, 32'h100);
        serve("r0", 32'h100, 32'h2021_FFFF, 0);
        check("r0_instr", instr, 32'h2021_FFFF);
        check("r0_ipc",   instr_pc, 32'h100);

        // Redirect and ready in the same HOLD cycle: the PC must not advance
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("hr_valid", {31'b0, instr_valid}, 32'd0);
        check("hr_req",   {31'b0, imem_req}, 32'd1);
        check("hr_addr",  imem_addr, 32'h200);
        serve("r1", 32'h200, 32'h1000_0003, 0);
        check("r1_ipc", instr_pc, 32'h200);

        // Redirect to the last word; the following fetch wraps to 0
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        serve("w0", 32'hFFFF_FFFC, 32'h2401_0001, 0);
        check("w0_ipc", instr_pc, 32'hFFFF_FFFC);
        serve("w1", 32'h0, 32'h2402_0002, 0);
        check("w1_ipc", instr_pc, 32'h0);
        check("w1_err", {31'b0, fetch_err}, 32'd0);

        // No ack: request stays up for 16 cycles, then the error trap
        wait_req("to");
        check("to_addr", imem_addr, 32'h4);
        repeat (15) step();
        check("to_req15", {31'b0, imem_req}, 32'd1);
        check("to_err15", {31'b0, fetch_err}, 32'd0);
        step();
        check("to_err16",   {31'b0, fetch_err}, 32'd1);
        check("to_req16",   {31'b0, imem_req}, 32'd0);
        check("to_valid16", {31'b0, instr_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        step();
        redirect_valid = 1'b0;
        step();
        check("err_sticky", {31'b0, fetch_err}, 32'd1);
        check("err_noreq",  {31'b0, imem_req}, 32'd0);

        // Reset clears the error and fetching restarts at the reset vector
        rst_n = 1'b0;
        #1;
        check("rr_err", {31'b0, fetch_err}, 32'd0);
        check("rr_req", {31'b0, imem_req}, 32'd0);
        step();
        rst_n = 1'b1;
        wait_req("rr");
        check("rr_addr", imem_addr, 32'h0);

        // Misaligned redirect traps immediately
        redirect_valid = 1'b1;
        redirect_pc    = 32'h102;
        step();
        redirect_valid = 1'b0;
        check("mis_err",   {31'b0, fetch_err}, 32'd1);
        check("mis_req",   {31'b0, imem_req}, 32'd0);
        check("mis_valid", {31'b0, instr_valid}, 32'd0);

        // Recover once more and complete a normal fetch
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        serve("z0", 32'h0, 32'h3442_1862, 0);
        check("z0_ipc", instr_pc, 32'h0);
        check("z0_err", {31'b0, fetch_err}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
